// File: rtl/tlp_pkg.sv
// Shared TLP decode constants, header field positions and decoder state type.
package tlp_pkg;

  // Format/type codes of the two supported request TLPs.
  localparam logic [1:0] FMT_MWR32 = 2'b10;
  localparam logic [1:0] FMT_MRD32 = 2'b00;
  localparam logic [4:0] TYPE_MEM  = 5'b00000;
  localparam logic [9:0] LEN_ONE   = 10'd1;

  // Header DW0 field positions.
  localparam int H0_FMT_HI  = 30;
  localparam int H0_FMT_LO  = 29;
  localparam int H0_TYPE_HI = 28;
  localparam int H0_TYPE_LO = 24;
  localparam int H0_LEN_HI  = 9;
  localparam int H0_LEN_LO  = 0;

  // Header DW1 field positions.
  localparam int H1_REQID_HI = 31;
  localparam int H1_REQID_LO = 16;
  localparam int H1_TAG_HI   = 15;
  localparam int H1_TAG_LO   = 8;
  localparam int H1_BE_HI    = 3;
  localparam int H1_BE_LO    = 0;

  // Header DW2 field positions: dword address starts at bit 2, bit 2 also
  // tells whether the payload DW shares the beat with DW2.
  localparam int H2_ADDR_LO    = 2;
  localparam int H2_ODD_BIT    = 2;
  localparam int H2_LOWADDR_HI = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR2    = 3'd1,
    ST_DATA    = 3'd2,
    ST_SKIP    = 3'd3,
    ST_RD_WAIT = 3'd4
  } tlp_state_e;

endpackage

// File: rtl/tlp_rx_decoder.sv
// Host->FPGA TLP receive decoder: turns MWr32/MRd32 single-DW requests into
// BAR0 register write strobes and read requests, discarding everything else.
//
// Handshakes: a receive beat transfers on a rising edge where rxValid_in and
// rxReady_out are both 1; a read request transfers on a rising edge where
// rdValid_out and rdReady_in are both 1, and rd* stay stable until then.
module tlp_rx_decoder
  import tlp_pkg::*;
#(
  parameter int REG_ABITS = 7
) (
  input  logic                 pcieClk_in,
  input  logic                 pcieNReset_in,
  input  logic [63:0]          rxData_in,
  input  logic                 rxSOP_in,
  input  logic                 rxEOP_in,
  input  logic                 rxValid_in,
  output logic                 rxReady_out,
  output logic [REG_ABITS-1:0] wrAddr_out,
  output logic [31:0]          wrData_out,
  output logic [3:0]           wrByteEn_out,
  output logic                 wrValid_out,
  output logic [REG_ABITS-1:0] rdAddr_out,
  output logic [15:0]          rdReqID_out,
  output logic [7:0]           rdTag_out,
  output logic [6:0]           rdLowAddr_out,
  output logic                 rdValid_out,
  input  logic                 rdReady_in,
  output logic [15:0]          dropCount_out,
  output tlp_state_e           dbgState_out
);

  tlp_state_e state_q, state_d;
  logic       ready_en_q;

  // Latched header DW0/DW1 fields of the TLP in flight.
  logic [1:0]  fmt_q;
  logic [4:0]  type_q;
  logic [9:0]  len_q;
  logic [15:0] reqid_q;
  logic [7:0]  tag_q;
  logic [3:0]  be_q;

  logic [REG_ABITS-1:0] pend_addr_q;

  logic                 wr_valid_q;
  logic [REG_ABITS-1:0] wr_addr_q;
  logic [31:0]          wr_data_q;
  logic [3:0]           wr_be_q;

  logic [REG_ABITS-1:0] rd_addr_q;
  logic [15:0]          rd_reqid_q;
  logic [7:0]           rd_tag_q;
  logic [6:0]           rd_low_q;

  logic [15:0] drop_q;

  logic        beat;
  logic [31:0] lo_dw;
  logic [31:0] hi_dw;
  logic        is_mwr;
  logic        is_mrd;

  // FSM control decoded alongside the next state.
  logic latch_hdr;
  logic wr_fire;
  logic wr_sel_hi;
  logic pend_load;
  logic rd_load;
  logic drop_inc;

  assign lo_dw = rxData_in[31:0];
  assign hi_dw = rxData_in[63:32];

  // Ready stays low in reset and until the first clock after release.
  assign rxReady_out = ready_en_q && (state_q != ST_RD_WAIT);
  assign beat        = rxValid_in && rxReady_out;

  assign is_mwr = (fmt_q == FMT_MWR32) && (type_q == TYPE_MEM) && (len_q == LEN_ONE);
  assign is_mrd = (fmt_q == FMT_MRD32) && (type_q == TYPE_MEM) && (len_q == LEN_ONE);

  // State register and the post-reset ready enable.
  always_ff @(posedge pcieClk_in or negedge pcieNReset_in) begin
    if (!pcieNReset_in) begin
      state_q    <= ST_IDLE;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
    end
  end

  // Next-state and per-beat control decode.
  always_comb begin
    state_d   = state_q;
    latch_hdr = 1'b0;
    wr_fire   = 1'b0;
    wr_sel_hi = 1'b0;
    pend_load = 1'b0;
    rd_load   = 1'b0;
    drop_inc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (beat && rxSOP_in) begin
          latch_hdr = 1'b1;
          state_d   = ST_HDR2;
        end
      end
      ST_HDR2: begin
        if (beat) begin
          if (rxSOP_in) begin
            // Truncated TLP: drop it and restart on the new header.
            drop_inc  = 1'b1;
            latch_hdr = 1'b1;
            state_d   = ST_HDR2;
          end else if (is_mwr) begin
            if (lo_dw[H2_ODD_BIT]) begin
              wr_fire   = 1'b1;
              wr_sel_hi = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              pend_load = 1'b1;
              state_d   = ST_DATA;
            end
          end else if (is_mrd) begin
            rd_load = 1'b1;
            state_d = ST_RD_WAIT;
          end else begin
            drop_inc = 1'b1;
            state_d  = rxEOP_in ? ST_IDLE : ST_SKIP;
          end
        end
      end
      ST_DATA: begin
        if (beat) begin
          if (rxSOP_in) begin
            drop_inc  = 1'b1;
            latch_hdr = 1'b1;
            state_d   = ST_HDR2;
          end else begin
            wr_fire = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_SKIP: begin
        if (beat && rxEOP_in) state_d = ST_IDLE;
      end
      ST_RD_WAIT: begin
        if (rdReady_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Header DW0/DW1 capture and the pending write address for 3-beat writes.
  always_ff @(posedge pcieClk_in or negedge pcieNReset_in) begin
    if (!pcieNReset_in) begin
      fmt_q       <= '0;
      type_q      <= '0;
      len_q       <= '0;
      reqid_q     <= '0;
      tag_q       <= '0;
      be_q        <= '0;
      pend_addr_q <= '0;
    end else begin
      if (latch_hdr) begin
        fmt_q   <= lo_dw[H0_FMT_HI:H0_FMT_LO];
        type_q  <= lo_dw[H0_TYPE_HI:H0_TYPE_LO];
        len_q   <= lo_dw[H0_LEN_HI:H0_LEN_LO];
        reqid_q <= hi_dw[H1_REQID_HI:H1_REQID_LO];
        tag_q   <= hi_dw[H1_TAG_HI:H1_TAG_LO];
        be_q    <= hi_dw[H1_BE_HI:H1_BE_LO];
      end
      if (pend_load) pend_addr_q <= lo_dw[REG_ABITS+1:H2_ADDR_LO];
    end
  end

  // Register write port: one-cycle strobe, fields held until the next write.
  always_ff @(posedge pcieClk_in or negedge pcieNReset_in) begin
    if (!pcieNReset_in) begin
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_be_q    <= '0;
    end else begin
      wr_valid_q <= wr_fire;
      if (wr_fire) begin
        wr_addr_q <= wr_sel_hi ? lo_dw[REG_ABITS+1:H2_ADDR_LO] : pend_addr_q;
        wr_data_q <= wr_sel_hi ? hi_dw : lo_dw;
        wr_be_q   <= be_q;
      end
    end
  end

  // Read request fields, captured at the DW2 beat and held through RD_WAIT.
  always_ff @(posedge pcieClk_in or negedge pcieNReset_in) begin
    if (!pcieNReset_in) begin
      rd_addr_q  <= '0;
      rd_reqid_q <= '0;
      rd_tag_q   <= '0;
      rd_low_q   <= '0;
    end else if (rd_load) begin
      rd_addr_q  <= lo_dw[REG_ABITS+1:H2_ADDR_LO];
      rd_reqid_q <= reqid_q;
      rd_tag_q   <= tag_q;
      rd_low_q   <= lo_dw[H2_LOWADDR_HI:0];
    end
  end

  // Saturating count of discarded TLPs.
  always_ff @(posedge pcieClk_in or negedge pcieNReset_in) begin
    if (!pcieNReset_in) begin
      drop_q <= '0;
    end else if (drop_inc && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign wrValid_out   = wr_valid_q;
  assign wrAddr_out    = wr_addr_q;
  assign wrData_out    = wr_data_q;
  assign wrByteEn_out  = wr_be_q;
  assign rdValid_out   = (state_q == ST_RD_WAIT);
  assign rdAddr_out    = rd_addr_q;
  assign rdReqID_out   = rd_reqid_q;
  assign rdTag_out     = rd_tag_q;
  assign rdLowAddr_out = rd_low_q;
  assign dropCount_out = drop_q;
  assign dbgState_out  = state_q;

endmodule
